// File: rtl/instr_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide, big-endian instruction memory
// and keeps the core in reset until a program image has loaded without error.
module instr_mem_loader #(
    parameter int MEM_SIZE = 2048,
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WAIT_WORD,
        WRITE,
        FIN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  word_count;
    logic [31:0]       word_reg;
    logic [1:0]        bidx;
    logic              err_reg;
    logic              hold_reg;
    logic              set_err;
    logic              out_of_bounds;
    logic [ADDR_W:0]   last_byte;

    // One extra bit so a word near the top of the address space cannot wrap past the check.
    assign last_byte     = {1'b0, addr_reg} + (ADDR_W+1)'(3);
    assign out_of_bounds = last_byte > (ADDR_W+1)'(MEM_SIZE - 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 8'h00;
        busy       = 1'b0;
        done       = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (addr_reg[1:0] != 2'b00) begin
                    set_err    = 1'b1;
                    state_next = FIN;
                end else if (remaining == '0) begin
                    state_next = FIN;
                end else begin
                    state_next = WAIT_WORD;
                end
            end
            WAIT_WORD: begin
                busy = 1'b1;
                if (out_of_bounds) begin
                    set_err    = 1'b1;
                    state_next = FIN;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = addr_reg + ADDR_W'(bidx);
                case (bidx)
                    2'd0:    mem_wdata = word_reg[31:24];
                    2'd1:    mem_wdata = word_reg[23:16];
                    2'd2:    mem_wdata = word_reg[15:8];
                    default: mem_wdata = word_reg[7:0];
                endcase
                if (bidx == 2'd3) begin
                    state_next = (remaining == LEN_W'(1)) ? FIN : WAIT_WORD;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_reg   <= '0;
            remaining  <= '0;
            word_count <= '0;
            word_reg   <= '0;
            bidx       <= 2'd0;
            err_reg    <= 1'b0;
            hold_reg   <= 1'b1;
        end else begin
            if (set_err) begin
                err_reg <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (load_start) begin
                        addr_reg   <= start_addr;
                        remaining  <= load_len;
                        err_reg    <= 1'b0;
                        word_count <= '0;
                        hold_reg   <= 1'b1;
                    end
                end
                WAIT_WORD: begin
                    if (in_ready && in_valid) begin
                        word_reg <= in_data;
                        bidx     <= 2'd0;
                    end
                end
                WRITE: begin
                    bidx <= bidx + 2'd1;
                    if (bidx == 2'd3) begin
                        addr_reg   <= addr_reg + ADDR_W'(4);
                        remaining  <= remaining - LEN_W'(1);
                        word_count <= word_count + LEN_W'(1);
                    end
                end
                FIN: begin
                    hold_reg <= err_reg;
                end
                default: begin
                end
            endcase
        end
    end

    // The core is released during the FIN cycle itself, not one cycle later.
    assign cpu_hold     = hold_reg & ~((state == FIN) & ~err_reg);
    assign err          = err_reg;
    assign words_loaded = word_count;

endmodule
